// File: rtl/result_wb_arbiter_pkg.sv
// Payload types shared by the writeback arbiter and its neighbours.
package result_wb_arbiter_pkg;

   localparam int unsigned SQN_W    = 7;
   localparam int unsigned TAG_W    = 7;
   localparam int unsigned NM_W     = 5;
   localparam int unsigned RESULT_W = 32;
   localparam int unsigned FLAGS_W  = 4;
   localparam int unsigned PC_W     = 32;

   // Branch/flush broadcast: everything younger than sqN dies when taken.
   typedef struct packed {
      logic             taken;
      logic [SQN_W-1:0] sqN;
   } BranchProv;

   // Execution result heading for writeback.
   typedef struct packed {
      logic                valid;
      logic [SQN_W-1:0]    sqN;
      logic [TAG_W-1:0]    tagDst;
      logic [NM_W-1:0]     nmDst;
      logic [RESULT_W-1:0] result;
      logic [FLAGS_W-1:0]  flags;
      logic [PC_W-1:0]     pc;
   } RES_UOp;

endpackage

// File: rtl/result_wb_arbiter.sv
// Writeback arbiter: single-cycle pipeline result has absolute priority,
// multi-cycle units share the remaining slots round-robin, and a starving
// multi-cycle unit raises a stall request towards issue.
module result_wb_arbiter
   import result_wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MC        = 2,
   parameter int unsigned STARVE_THRESH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  BranchProv         IN_branch,
   input  RES_UOp            IN_primUop,
   input  RES_UOp            IN_mcUop [NUM_MC],
   output logic [NUM_MC-1:0] OUT_wbAvail,
   output logic              OUT_stallPrim,
   output RES_UOp            OUT_uop
);

   localparam int unsigned IDX_W = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;
   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MC - 1);

   // Modular sequence compare: a positive signed distance means younger than the branch.
   function automatic logic is_killed(input BranchProv br, input logic [SQN_W-1:0] sqn);
      logic [SQN_W-1:0] diff;
      diff = sqn - br.sqN;
      return br.taken && ($signed(diff) > $signed(SQN_W'(0)));
   endfunction

   logic              prim_elig;
   logic [NUM_MC-1:0] mc_elig;
   logic [NUM_MC-1:0] grant;
   logic [IDX_W-1:0]  grant_idx;
   logic              grant_found;

   logic [IDX_W-1:0]  rr_q, rr_d;
   logic [CNT_W-1:0]  wait_q [NUM_MC];
   logic [CNT_W-1:0]  wait_d [NUM_MC];
   logic              stall_q, stall_d;
   RES_UOp            uop_q, uop_d;

   // Eligibility of every input after the current-cycle flush filter.
   always_comb begin
      prim_elig = IN_primUop.valid && !is_killed(IN_branch, IN_primUop.sqN);
      mc_elig   = '0;
      for (int unsigned i = 0; i < NUM_MC; i++) begin
         mc_elig[i] = IN_mcUop[i].valid && !is_killed(IN_branch, IN_mcUop[i].sqN);
      end
   end

   // Round-robin search from rr_q; grant only when the primary slot is free and not in reset.
   always_comb begin
      int unsigned idx;
      idx         = 0;
      grant       = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int unsigned k = 0; k < NUM_MC; k++) begin
         idx = 32'(rr_q) + k;
         if (idx >= NUM_MC) idx = idx - NUM_MC;
         if (!grant_found && mc_elig[IDX_W'(idx)]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(idx);
         end
      end
      if (!rst && !prim_elig && grant_found) grant[grant_idx] = 1'b1;
   end

   assign OUT_wbAvail = grant;

   // Next pointer, selected result, wait counters and stall request.
   always_comb begin
      rr_d    = rr_q;
      uop_d   = '0;
      stall_d = 1'b0;
      if (|grant) rr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
      if (prim_elig) begin
         uop_d       = IN_primUop;
         uop_d.valid = 1'b1;
      end else if (|grant) begin
         uop_d       = IN_mcUop[grant_idx];
         uop_d.valid = 1'b1;
      end
      for (int unsigned i = 0; i < NUM_MC; i++) begin
         wait_d[i] = '0;
         if (mc_elig[i] && !grant[i]) begin
            wait_d[i] = (wait_q[i] == CNT_MAX) ? CNT_MAX : wait_q[i] + CNT_W'(1);
         end
         if (32'(wait_d[i]) >= STARVE_THRESH) stall_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q    <= '0;
         stall_q <= 1'b0;
         uop_q   <= '0;
         for (int unsigned i = 0; i < NUM_MC; i++) wait_q[i] <= '0;
      end else begin
         rr_q    <= rr_d;
         stall_q <= stall_d;
         uop_q   <= uop_d;
         for (int unsigned i = 0; i < NUM_MC; i++) wait_q[i] <= wait_d[i];
      end
   end

   assign OUT_stallPrim = stall_q;
   assign OUT_uop       = uop_q;

endmodule

// File: tb/tb_result_wb_arbiter.sv
// Directed bench for the writeback arbiter with hand-computed expectations.
module tb_result_wb_arbiter;
   import result_wb_arbiter_pkg::*;

   logic      clk;
   logic      rst;
   BranchProv branch;
   RES_UOp    prim;
   RES_UOp    mc [2];
   logic [1:0] wb_avail;
   logic      stall;
   RES_UOp    uop;

   int errors = 0;
   int checks = 0;

   result_wb_arbiter #(.NUM_MC(2), .STARVE_THRESH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .IN_branch    (branch),
      .IN_primUop   (prim),
      .IN_mcUop     (mc),
      .OUT_wbAvail  (wb_avail),
      .OUT_stallPrim(stall),
      .OUT_uop      (uop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic RES_UOp mk(input logic v, input logic [6:0] sqn, input logic [31:0] res);
      RES_UOp u;
      u.valid  = v;
      u.sqN    = sqn;
      u.tagDst = sqn ^ 7'h55;
      u.nmDst  = res[4:0];
      u.result = res;
      u.flags  = res[3:0] ^ 4'hA;
      u.pc     = res ^ 32'hA5A5_0000;
      return u;
   endfunction

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      branch = '0;
      prim   = '0;
      mc[0]  = '0;
      mc[1]  = '0;
      step();
      // Grant suppressed during reset even with a valid mc input.
      mc[0] = mk(1'b1, 7'd1, 32'h11);
      settle();
      check("rst_wbavail", 64'(wb_avail), 64'd0);
      step();
      check("rst_valid", 64'(uop.valid), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      rst   = 1'b0;
      mc[0] = '0;

      // Primary only.
      prim = mk(1'b1, 7'd5, 32'h3F80_0000);
      settle();
      check("prim_wbavail", 64'(wb_avail), 64'd0);
      step();
      prim = '0;
      check("prim_valid", 64'(uop.valid), 64'd1);
      check("prim_result", 64'(uop.result), 64'h3F80_0000);
      check("prim_sqn", 64'(uop.sqN), 64'd5);
      check("prim_pc", 64'(uop.pc), 64'h9A25_0000);
      check("prim_tag", 64'(uop.tagDst), 64'h50);
      check("prim_flags", 64'(uop.flags), 64'hA);
      step();
      check("idle_valid", 64'(uop.valid), 64'd0);

      // Round-robin between held mc inputs starting at port 0.
      mc[0] = mk(1'b1, 7'd6, 32'hA0);
      mc[1] = mk(1'b1, 7'd7, 32'hA1);
      settle();
      check("rr_c0_wbavail", 64'(wb_avail), 64'd1);
      step();
      mc[0] = '0;
      check("rr_c0_result", 64'(uop.result), 64'hA0);
      settle();
      check("rr_c1_wbavail", 64'(wb_avail), 64'd2);
      step();
      mc[1] = '0;
      check("rr_c1_result", 64'(uop.result), 64'hA1);
      check("rr_c1_nm", 64'(uop.nmDst), 64'h01);
      settle();
      check("rr_idle_wbavail", 64'(wb_avail), 64'd0);

      // Starvation: mc0 waits behind six primary results.
      mc[0] = mk(1'b1, 7'd8, 32'hB0);
      for (int i = 1; i <= 6; i++) begin
         prim = mk(1'b1, 7'(20 + i), 32'(100 + i));
         settle();
         check($sformatf("starve_wbavail_%0d", i), 64'(wb_avail), 64'd0);
         step();
         check($sformatf("starve_stall_%0d", i), 64'(stall), (i >= 4) ? 64'd1 : 64'd0);
         check($sformatf("starve_result_%0d", i), 64'(uop.result), 64'(100 + i));
      end
      prim = '0;
      settle();
      check("starve_grant", 64'(wb_avail), 64'd1);
      check("starve_stall_held", 64'(stall), 64'd1);
      step();
      mc[0] = '0;
      check("starve_mc0_result", 64'(uop.result), 64'hB0);
      check("starve_stall_fall", 64'(stall), 64'd0);
      // rr pointer is now 1.

      // Flush: younger mc1 is killed, older mc1 is granted.
      branch = '{taken: 1'b1, sqN: 7'd10};
      mc[1]  = mk(1'b1, 7'd12, 32'hC1);
      settle();
      check("flush_kill_wbavail", 64'(wb_avail), 64'd0);
      step();
      check("flush_kill_valid", 64'(uop.valid), 64'd0);
      mc[1] = mk(1'b1, 7'd9, 32'hC2);
      settle();
      check("flush_old_wbavail", 64'(wb_avail), 64'd2);
      step();
      mc[1] = '0;
      check("flush_old_valid", 64'(uop.valid), 64'd1);
      check("flush_old_sqn", 64'(uop.sqN), 64'd9);
      // Killed primary does not block an eligible mc input.
      prim  = mk(1'b1, 7'd11, 32'hD0);
      mc[0] = mk(1'b1, 7'd3, 32'hD1);
      settle();
      check("flush_prim_wbavail", 64'(wb_avail), 64'd1);
      step();
      prim  = '0;
      mc[0] = '0;
      check("flush_prim_result", 64'(uop.result), 64'hD1);

      // Wrap-around sequence numbers.
      branch = '{taken: 1'b1, sqN: 7'h7E};
      mc[0]  = mk(1'b1, 7'h01, 32'hE0);
      settle();
      check("wrap_kill_wbavail", 64'(wb_avail), 64'd0);
      step();
      check("wrap_kill_valid", 64'(uop.valid), 64'd0);
      mc[0] = mk(1'b1, 7'h7D, 32'hE1);
      settle();
      check("wrap_old_wbavail", 64'(wb_avail), 64'd1);
      step();
      mc[0]  = '0;
      branch = '0;
      check("wrap_old_result", 64'(uop.result), 64'hE1);
      // rr pointer is now 1.

      // Build a stall with rr at 1, then reset mid-stall.
      mc[0] = mk(1'b1, 7'd30, 32'hF0);
      for (int i = 0; i < 4; i++) begin
         prim = mk(1'b1, 7'(40 + i), 32'(200 + i));
         step();
      end
      prim = '0;
      check("pre_rst_stall", 64'(stall), 64'd1);
      rst = 1'b1;
      settle();
      check("mid_rst_wbavail", 64'(wb_avail), 64'd0);
      step();
      rst = 1'b0;
      check("post_rst_stall", 64'(stall), 64'd0);
      check("post_rst_valid", 64'(uop.valid), 64'd0);
      mc[1] = mk(1'b1, 7'd31, 32'hF1);
      settle();
      check("post_rst_first", 64'(wb_avail), 64'd1);
      step();
      mc[0] = '0;
      check("post_rst_mc0", 64'(uop.result), 64'hF0);
      settle();
      check("post_rst_second", 64'(wb_avail), 64'd2);
      step();
      mc[1] = '0;
      check("post_rst_mc1", 64'(uop.result), 64'hF1);
      step();
      check("end_valid", 64'(uop.valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
